sliding_window_stream: RTL

Parametrised successor to the single-channel sliding window generator. Accepts a raster-order pixel stream with a valid/ready handshake and multiple channels per pixel. Emits KERNEL_DIM x KERNEL_DIM windows at a configurable stride, with output backpressure and per-window position tags. Sits between the pixel source and the max-pooling/convolution compute stage.

---
 rtl/sliding_window_pkg.sv | 29 ++
 rtl/sliding_window_stream_line_buffer.sv | 39 +++
 rtl/sliding_window_stream.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sliding_window_pkg.sv
// Shared helpers for the sliding window stream block:
// window bit offsets, counter widths and window counts.
package sliding_window_pkg;

   // Counter width that stays legal for a modulus of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int window_idx(
      input int ch,
      input int r,
      input int c,
      input int k,
      input int dw
   );
      return ((ch * k + r) * k + c) * dw;
   endfunction

   function automatic int windows_per_frame(
      input int rs,
      input int cs,
      input int k,
      input int s
   );
      return ((rs - k) / s + 1) * ((cs - k) / s + 1);
   endfunction

endpackage

// File: rtl/sliding_window_stream_line_buffer.sv
// One-row delay line: circular buffer whose shared read/write
// pointer advances on every accepted pixel.
module line_buffer
   import sliding_window_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = cnt_w(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;

   // Read-before-write: dout is the entry written one row ago.
   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/sliding_window_stream.sv
// Raster-order pixel stream to KxK windows at a given stride,
// multi-channel, with valid/ready on both sides.
module sliding_window_stream
   import sliding_window_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int KERNEL_DIM = 3,
   parameter int ROW_SIZE   = 5,
   parameter int COL_SIZE   = 5,
   parameter int STRIDE     = 1,
   parameter int CHANNELS   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_pixel,
   output logic out_valid,
   input  logic out_ready,
   output logic [CHANNELS*KERNEL_DIM*KERNEL_DIM*DATA_WIDTH-1:0] out_window,
   output logic [$clog2(COL_SIZE)-1:0] out_row,
   output logic [$clog2(ROW_SIZE)-1:0] out_col,
   output logic frame_done
);

   localparam int K  = KERNEL_DIM;
   localparam int DW = DATA_WIDTH;
   localparam int PW = CHANNELS * DATA_WIDTH;
   localparam int WW = CHANNELS * K * K * DATA_WIDTH;
   localparam int RW = $clog2(COL_SIZE);
   localparam int CW = $clog2(ROW_SIZE);
   localparam int SW = cnt_w(STRIDE);

   localparam logic [CW-1:0] COL_LAST  = CW'(ROW_SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(COL_SIZE - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
   localparam logic [SW-1:0] PH_LAST   = SW'(STRIDE - 1);

   logic          accept;
   logic          emit;
   logic          last_px;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [SW-1:0] col_ph;
   logic [SW-1:0] row_ph;
   logic [PW-1:0] lb_in  [K-1];
   logic [PW-1:0] lb_out [K-1];
   logic [PW-1:0] tap    [K];
   logic [WW-1:0] win_q;
   logic [WW-1:0] win_d;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign last_px  = (row == ROW_LAST) && (col == COL_LAST);

   // Phase counters are zero exactly on stride-aligned positions.
   assign emit = accept
              && (row >= ROW_FIRST) && (col >= COL_FIRST)
              && (row_ph == '0) && (col_ph == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col    <= '0;
            col_ph <= '0;
            row    <= (row == ROW_LAST) ? '0 : row + RW'(1);
            row_ph <= (row == ROW_LAST || row < ROW_FIRST
                       || row_ph == PH_LAST) ? '0 : row_ph + SW'(1);
         end else begin
            col    <= col + CW'(1);
            col_ph <= (col < COL_FIRST || col_ph == PH_LAST)
                    ? '0 : col_ph + SW'(1);
         end
      end
   end

   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      if (i == 0) begin : g_head
         assign lb_in[i] = in_pixel;
      end else begin : g_link
         assign lb_in[i] = lb_out[i-1];
      end
      line_buffer #(
         .DEPTH (ROW_SIZE),
         .WIDTH (PW)
      ) u_lb (
         .clk  (clk),
         .rst  (rst),
         .en   (accept),
         .din  (lb_in[i]),
         .dout (lb_out[i])
      );
   end

   // tap[0] is the oldest row, tap[K-1] the incoming pixel.
   for (genvar r = 0; r < K - 1; r++) begin : g_tap
      assign tap[r] = lb_out[K-2-r];
   end
   assign tap[K-1] = in_pixel;

   always_comb begin
      win_d = win_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[window_idx(ch, r, c, K, DW) +: DW] =
                  win_q[window_idx(ch, r, c + 1, K, DW) +: DW];
            end
            win_d[window_idx(ch, r, K - 1, K, DW) +: DW] =
               tap[r][ch*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         win_q <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_window <= '0;
         out_row    <= '0;
         out_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && last_px;
         if (emit) begin
            out_valid  <= 1'b1;
            out_window <= win_d;
            out_row    <= row - ROW_FIRST;
            out_col    <= col - COL_FIRST;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule
